// File: rtl/ps2_mouse_packer.sv
// Assembles 3-byte PS/2 mouse packets into a 25-bit word {strobe, Y, X, status}.
// Drops stray or framing-invalid leading bytes, aborts partial packets on timeout, and can saturate overflowed deltas.
module ps2_mouse_packer #(
  parameter int TIMEOUT   = 100000,
  parameter int TO_W      = 17,
  parameter bit CLAMP_OVF = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [24:0] ps2_mouse,
  output logic        pkt_valid,
  output logic        sync_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  // Overflowed deltas saturate toward their sign: negative -> 8'h80, positive -> 8'h7F.
  function automatic logic [7:0] clamp_delta(input logic ovf, input logic sign, input logic [7:0] raw);
    logic [7:0] res;
    if (CLAMP_OVF && ovf) begin
      res = sign ? 8'h80 : 8'h7F;
    end else begin
      res = raw;
    end
    return res;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_nxt;
  logic [7:0]      r_b0;
  logic [7:0]      r_b1;
  logic [24:0]     r_ps2_mouse;
  logic            r_pkt_valid;
  logic            r_sync_err;
  logic            w_accept_b0;
  logic            w_accept_b1;
  logic            w_done;
  logic            w_abort;
  logic            w_to_hit;
  logic [24:0]     w_word;

  assign w_to_hit = (r_to_cnt == TO_MAX);

  // Next-state decode, packet-boundary and abort detection.
  always_comb begin
    w_state_nxt = r_state;
    w_accept_b0 = 1'b0;
    w_accept_b1 = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      WAIT_B0: begin
        if (byte_valid && byte_data[3] && (byte_data != 8'hFA) && (byte_data != 8'hAA)) begin
          w_state_nxt = WAIT_B1;
          w_accept_b0 = 1'b1;
        end else begin
          w_state_nxt = WAIT_B0;
        end
      end
      WAIT_B1: begin
        if (byte_valid) begin
          w_state_nxt = WAIT_B2;
          w_accept_b1 = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = WAIT_B0;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = WAIT_B1;
        end
      end
      WAIT_B2: begin
        if (byte_valid) begin
          w_state_nxt = WAIT_B0;
          w_done      = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = WAIT_B0;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = WAIT_B2;
        end
      end
      default: begin
        w_state_nxt = WAIT_B0;
      end
    endcase
  end

  // Inter-byte timer: idle in WAIT_B0, restarts on each byte, saturates at TIMEOUT.
  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    if (byte_valid || (r_state == WAIT_B0)) begin
      w_to_cnt_nxt = TO_ZERO;
    end else if (w_to_hit) begin
      w_to_cnt_nxt = r_to_cnt;
    end else begin
      w_to_cnt_nxt = r_to_cnt + TO_ONE;
    end
  end

  // The third byte feeds the output word directly so it lands one clock after arrival.
  assign w_word = {~r_ps2_mouse[24],
                   clamp_delta(r_b0[7], r_b0[5], byte_data),
                   clamp_delta(r_b0[6], r_b0[4], r_b1),
                   r_b0};

  // State, timer and byte capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= WAIT_B0;
      r_to_cnt <= TO_ZERO;
      r_b0     <= 8'h00;
      r_b1     <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      if (w_accept_b0) begin
        r_b0 <= byte_data;
      end
      if (w_accept_b1) begin
        r_b1 <= byte_data;
      end
    end
  end

  // Registered outputs; the word holds between packets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ps2_mouse <= 25'h0;
      r_pkt_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_pkt_valid <= w_done;
      r_sync_err  <= w_abort;
      if (w_done) begin
        r_ps2_mouse <= w_word;
      end
    end
  end

  assign ps2_mouse = r_ps2_mouse;
  assign pkt_valid = r_pkt_valid;
  assign sync_err  = r_sync_err;
  assign busy      = (r_state == WAIT_B1) || (r_state == WAIT_B2);

endmodule
